// File: rtl/fp_pkg.sv
// Shared types and constants for the iterative floating-point multiplier:
// operand classes, FSM states, result flags and special-value encodings.
package fp_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } op_class_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_FIN,
    S_DONE
  } state_e;

  typedef struct packed {
    logic nan;
    logic zero;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  localparam int FP_MAX_W = 64;

  // Unsigned encodings; callers truncate to 1+exp_w+man_w and add the sign.
  function automatic logic [FP_MAX_W-1:0] fp_inf_bits(input int exp_w, input int man_w);
    return ((64'd1 << exp_w) - 64'd1) << man_w;
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_nan_bits(input int exp_w, input int man_w);
    return fp_inf_bits(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

  // Denormals land in CLS_ZERO: they are flushed, never multiplied.
  function automatic op_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic frac_zero);
    if (exp_zero)      return CLS_ZERO;
    else if (exp_ones) return frac_zero ? CLS_INF : CLS_NAN;
    else               return CLS_NORM;
  endfunction

endpackage

// File: rtl/mant_mul_iter.sv
// Iterative M x M significand multiplier: retires STEP multiplier bits per
// cycle by shift-add, finishing in N = ceil(M/STEP) cycles after start.
module mant_mul_iter #(
  parameter int M    = 24,
  parameter int STEP = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [M-1:0]   a_in,
  input  logic [M-1:0]   b_in,
  output logic           busy,
  output logic           done,
  output logic [2*M-1:0] prod
);

  localparam int N     = (M + STEP - 1) / STEP;
  localparam int MW    = N * STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  logic [2*M-1:0]   mcand_q, mcand_d;
  logic [2*M-1:0]   acc_q, acc_d;
  logic [2*M-1:0]   pp;
  logic [MW-1:0]    mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  assign busy = busy_q;
  // High during the final iteration; prod is complete from the next cycle.
  assign done = busy_q && (cnt_q == CNT_W'(N - 1));
  assign prod = acc_q;

  always_comb begin
    pp = '0;
    for (int j = 0; j < STEP; j++) begin
      if (mplier_q[j]) pp = pp + (mcand_q << j);
    end
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no path leaves it unassigned (no latch).
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = (2*M)'(a_in);
      mplier_d = MW'(b_in);
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_q + pp;
      mcand_d  = mcand_q << STEP;
      mplier_d = mplier_q >> STEP;
      cnt_d    = cnt_q + 1'b1;
      if (done) busy_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/fp_mul_iter.sv
// Sequential IEEE-754-style multiplier: classifies operands, resolves specials
// at capture, runs the iterative significand core, then normalises and rounds (RNE).
module fp_mul_iter
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int STEP  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   z,
  output logic                   nan,
  output logic                   zero,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   inexact
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int M    = MAN_W + 1;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = 2**(EXP_W - 1) - 1;

  localparam logic [W-1:0]         Z_NAN = W'(fp_nan_bits(EXP_W, MAN_W));
  localparam logic [W-1:0]         Z_INF = W'(fp_inf_bits(EXP_W, MAN_W));
  localparam logic signed [EW-1:0] E_MAX = EW'(2**EXP_W - 1);

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  op_class_e        cls_a, cls_b;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign cls_a = fp_classify(ea == '0, &ea, fa == '0);
  assign cls_b = fp_classify(eb == '0, &eb, fb == '0);

  state_e                state_q, state_d;
  logic                  sign_q, sign_d;
  logic signed [EW-1:0]  exp_q, exp_d;
  logic [W-1:0]          z_q, z_d;
  fp_flags_t             flags_q, flags_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;

  logic                  mul_start, mul_busy, mul_done;
  logic [2*M-1:0]        prod;

  mant_mul_iter #(
    .M    (M),
    .STEP (STEP)
  ) u_mant (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a_in  ({1'b1, fa}),
    .b_in  ({1'b1, fb}),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (prod)
  );

  // Normalise and round the finished product.
  logic                 hi, guard, sticky, inc, carry;
  logic [MAN_W-1:0]     frac_t, frac_r;
  logic signed [EW-1:0] e_r;
  logic [W-1:0]         fin_z;
  fp_flags_t            fin_flags;

  always_comb begin
    hi        = prod[2*M-1];
    frac_t    = hi ? prod[2*M-2 -: MAN_W] : prod[2*M-3 -: MAN_W];
    guard     = hi ? prod[M-1] : prod[M-2];
    sticky    = hi ? |prod[M-2:0] : |prod[M-3:0];
    inc       = guard & (sticky | frac_t[0]);
    {carry, frac_r} = {1'b0, frac_t} + (MAN_W + 1)'(inc);
    e_r       = exp_q + EW'(hi) + EW'(carry);
    fin_flags = '0;
    if (e_r >= E_MAX) begin
      fin_z              = {sign_q, Z_INF[W-2:0]};
      fin_flags.overflow = 1'b1;
      fin_flags.inexact  = 1'b1;
    end else if (e_r <= $signed(EW'(0))) begin
      fin_z               = {sign_q, {(W-1){1'b0}}};
      fin_flags.underflow = 1'b1;
      fin_flags.zero      = 1'b1;
      fin_flags.inexact   = 1'b1;
    end else begin
      fin_z             = {sign_q, e_r[EXP_W-1:0], frac_r};
      fin_flags.inexact = guard | sticky;
    end
  end

  logic any_nan, any_inf, any_zero;
  assign any_nan  = (cls_a == CLS_NAN) || (cls_b == CLS_NAN);
  assign any_inf  = (cls_a == CLS_INF) || (cls_b == CLS_INF);
  assign any_zero = (cls_a == CLS_ZERO) || (cls_b == CLS_ZERO);

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    z_d         = z_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    mul_start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          flags_d    = '0;
          in_ready_d = 1'b0;
          sign_d     = sa ^ sb;
          if (any_nan || (any_inf && any_zero)) begin
            z_d         = Z_NAN;
            flags_d.nan = 1'b1;
            state_d     = S_DONE;
            out_valid_d = 1'b1;
          end else if (any_inf) begin
            z_d         = {sa ^ sb, Z_INF[W-2:0]};
            state_d     = S_DONE;
            out_valid_d = 1'b1;
          end else if (any_zero) begin
            z_d          = {sa ^ sb, {(W-1){1'b0}}};
            flags_d.zero = 1'b1;
            state_d      = S_DONE;
            out_valid_d  = 1'b1;
          end else begin
            exp_d     = EW'(ea) + EW'(eb) - EW'(BIAS);
            mul_start = 1'b1;
            state_d   = S_MUL;
          end
        end
      end
      // An idle core in MUL only follows a glitch; fall through rather than hang.
      S_MUL: if (mul_done || !mul_busy) state_d = S_FIN;
      S_FIN: begin
        z_d         = fin_z;
        flags_d     = fin_flags;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      z_q         <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      z_q         <= z_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign nan       = flags_q.nan;
  assign zero      = flags_q.zero;
  assign overflow  = flags_q.overflow;
  assign underflow = flags_q.underflow;
  assign inexact   = flags_q.inexact;

endmodule

// File: tb/tb_fp_mul_iter.sv
// Directed bench for fp_mul_iter (single precision, STEP=4): arithmetic,
// rounding, specials, latency, backpressure and mid-operation reset.
module tb_fp_mul_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] a_i, b_i, z_o;
  logic        out_valid, out_ready;
  logic        nan_o, zero_o, ovf_o, unf_o, inx_o;
  logic [4:0]  flags_o;

  int errors = 0;
  int checks = 0;

  assign flags_o = {nan_o, zero_o, ovf_o, unf_o, inx_o};

  always #5 clk = ~clk;

  fp_mul_iter #(.EXP_W(8), .MAN_W(23), .STEP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z_o),
    .nan       (nan_o),
    .zero      (zero_o),
    .overflow  (ovf_o),
    .underflow (unf_o),
    .inexact   (inx_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation, measure latency in cycles from the capture edge to
  // the first edge that sees out_valid, check result, then accept it.
  task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic [31:0] exp_z, input logic [4:0] exp_f, input int exp_lat);
    int lat;
    @(negedge clk);
    a_i = op_a;
    b_i = op_b;
    in_valid = 1'b1;
    check({tag, ".in_ready_idle"}, in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    check({tag, ".in_ready_busy"}, in_ready, 0);
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".z"}, z_o, exp_z);
    check({tag, ".flags"}, flags_o, exp_f);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, ".out_valid_drop"}, out_valid, 0);
    check({tag, ".in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_i = '0;
    b_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset.in_ready", in_ready, 1);
    check("reset.out_valid", out_valid, 0);
    check("reset.z", z_o, 0);
    check("reset.flags", flags_o, 0);

    // flags order: {nan, zero, overflow, underflow, inexact}
    run_op("mul_3x2.5",  32'h40400000, 32'h40200000, 32'h40F00000, 5'b00000, 8);
    run_op("mul_1x1",    32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 8);
    run_op("mul_3x3",    32'h40400000, 32'h40400000, 32'h41100000, 5'b00000, 8);
    run_op("rnd_sticky", 32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00001, 8);
    run_op("rnd_tie",    32'h3F800001, 32'h3FC00000, 32'h3FC00002, 5'b00001, 8);
    run_op("overflow",   32'h7F000000, 32'h40000000, 32'h7F800000, 5'b00101, 8);
    run_op("underflow",  32'h00800000, 32'h3F000000, 32'h00000000, 5'b01011, 8);
    run_op("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 5'b10000, 1);
    run_op("nan_in",     32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b10000, 1);
    run_op("ninf_x_2",   32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 1);
    run_op("nzero_x_1",  32'h80000000, 32'h3F800000, 32'h80000000, 5'b01000, 1);

    // Backpressure: result held for 5 cycles while a second request is offered.
    @(negedge clk);
    a_i = 32'h40400000;
    b_i = 32'h40200000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check("hold.out_valid", out_valid, 1);
    a_i = 32'h7F800000;
    b_i = 32'h00000000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold.z", z_o, 32'h40F00000);
      check("hold.flags", flags_o, 5'b00000);
      check("hold.in_ready", in_ready, 0);
      check("hold.out_valid_held", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("hold.released", out_valid, 0);
    check("hold.in_ready_back", in_ready, 1);

    // Reset during the third MUL cycle discards the operation.
    @(negedge clk);
    a_i = 32'h40400000;
    b_i = 32'h40400000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.out_valid", out_valid, 0);
    check("rst_mid.z", z_o, 0);
    check("rst_mid.flags", flags_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid.in_ready", in_ready, 1);
    check("rst_mid.no_result", out_valid, 0);
    run_op("after_rst", 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 5'b00001, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_mul_iter.md
# fp_mul_iter

Parametrised IEEE-754-style binary floating-point multiplier with valid/ready handshakes on both sides. The significand product is computed iteratively, STEP bits per cycle, followed by normalisation and round-to-nearest-even. Specials and exceptions are resolved fully, with flags. It is the sequential, width-generic successor to the combinational single-precision multiplier, and sits between operand-issue logic and the FP writeback path.

## Interface
- EXP_W, 8, exponent width; BIAS = 2^(EXP_W-1)-1
- MAN_W, 23, stored fraction width; significand M = MAN_W+1 bits
- STEP, 4, multiplier bits retired per cycle, 1..M; N = ceil(M/STEP)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a, b  in  1+EXP_W+MAN_W  operands {sign, exp, frac}
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- z  out  1+EXP_W+MAN_W  product
- nan, zero, overflow, underflow, inexact  out  1 each  result flags, valid with out_valid

## Operation
- FSM: IDLE -> MUL -> FIN -> DONE -> IDLE.
- Special results go IDLE -> DONE directly.
- in_ready = (state==IDLE). Operands are captured on in_valid&&in_ready.
- Operand classes, per operand:
  - exp==0 -> ZERO; denormals are flushed to zero.
  - exp==all-ones, frac==0 -> INF.
  - exp==all-ones, frac!=0 -> NAN.
  - otherwise NORM.
- Special resolution at capture, in priority order:
  - any NAN, or INF×ZERO -> canonical NaN {0, all-ones, 1, 0...}, nan=1.
  - any INF -> {sa^sb, all-ones, 0}, no overflow flag.
  - any ZERO -> {sa^sb, 0, 0}, zero=1.
- NORM×NORM datapath:
  - sign = sa^sb.
  - e = ea+eb-BIAS, held signed in EXP_W+2 bits.
  - MUL performs N cycles of shift-add on {1,fa}×{1,fb}, STEP multiplier bits per cycle, accumulating a 2M-bit product P.
- FIN, one cycle:
  - If P[2M-1]=1, take P[2M-2 -: MAN_W] and e+1; otherwise take P[2M-3 -: MAN_W].
  - guard = next bit below the taken fraction; sticky = OR of all remaining lower bits.
  - RNE: increment when guard&(sticky|lsb). On carry-out of the fraction, frac=0 and e+1.
  - e >= 2^EXP_W-1 -> {sign, all-ones, 0}, overflow=1, inexact=1.
  - e <= 0 -> {sign, 0, 0}, underflow=1, zero=1, inexact=1.
  - Otherwise normal result, with inexact = guard|sticky.
- DONE: out_valid=1. z and flags are held stable until out_ready; then return to IDLE.
- Flags are all cleared at every capture. nan, overflow and the INF result are mutually exclusive.

## Timing
- Normal operands: out_valid rises N+2 cycles after the capture edge. With defaults (N=6) that is 8 cycles.
- Special operands: out_valid rises 1 cycle after capture.
- Single outstanding operation. Throughput is one result per (latency + 1 + backpressure cycles). in_ready is low from the capture edge until the cycle after the out_valid&&out_ready edge.
- While in MUL, FIN or DONE, in_valid is ignored; operands are never overwritten.
- Asynchronous reset, including mid-MUL: state=IDLE, out_valid=0, z=0, all flags=0, accumulator=0, in_ready=1 after release. The in-flight operation is discarded.
- Reset values: in_ready=1, out_valid=0, z=0, nan=zero=overflow=underflow=inexact=0.

## Structure
- Shared package fp_pkg holds:
  - operand class enum (ZERO, NORM, INF, NAN);
  - FSM state enum;
  - canonical-NaN and Inf constant functions parametrised by EXP_W/MAN_W.
- One sub-module, mant_mul_iter: the M×M shift-add core with STEP/N parameters, start/busy/done, and a 2M-bit product. The top level owns classification, exponent, normalise/round and the handshakes.

## Test plan
- 0x40400000 × 0x40200000 (3.0×2.5): z=0x40F00000, all flags 0, out_valid exactly 8 cycles after capture.
- Rounding:
  - 0x3F800001 × 0x3F800001: z=0x3F800002, inexact=1 (sticky round-down).
  - 0x3F800001 × 0x3FC00000: z=0x3FC00002, inexact=1 (tie rounds to even).
- 0x7F000000 × 0x40000000: z=0x7F800000, overflow=1, inexact=1. 0x00800000 × 0x3F000000: z=0x00000000, underflow=1, zero=1.
- Specials:
  - 0x7F800000 × 0x00000000: z=0x7FC00000, nan=1, 1-cycle latency.
  - 0xFF800000 × 0x40000000: z=0xFF800000, no flags.
  - 0x80000000 × 0x3F800000: z=0x80000000, zero=1.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles: z and flags stable, in_ready=0, a second in_valid is ignored.
  - Pull rst_n low at MUL cycle 3: out_valid=0 immediately, in_ready=1 after release; the next operation completes correctly.
